// File: rtl/hazard_unit.sv
// Stall/flush control for a 5-stage MIPS pipeline: Tuse/Tnew data hazards plus mult/div busy.
// Optional stall counter is built only when HAZARD_STALL_STATS_EN is defined.
module hazard_unit #(
    parameter int unsigned TW          = 2,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   instr_D,
    input  logic [4:0]    rs_D,
    input  logic [4:0]    rt_D,
    input  logic [TW-1:0] Tnew_E,
    input  logic [TW-1:0] Tnew_M,
    input  logic [4:0]    WAG_E,
    input  logic [4:0]    WAG_M,
    input  logic          RegWrite_E,
    input  logic          RegWrite_M,
    input  logic          md_start_E,
    input  logic          md_is_div_E,
    input  logic          stats_clr,
    output logic          stall,
    output logic          flush_E,
    output logic          md_busy,
    output logic [15:0]   stall_cnt
);

    typedef enum logic {StIdle, StBusy} md_state_e;

    logic [5:0]    w_op;
    logic [5:0]    w_funct;
    logic [4:0]    w_rt_field;
    logic          w_rtype;
    logic          w_rs_use;
    logic          w_rt_use;
    logic [1:0]    w_tuse_rs;
    logic [1:0]    w_tuse_rt;
    logic          w_md_class;
    logic [TW-1:0] w_tuse_rs_tw;
    logic [TW-1:0] w_tuse_rt_tw;
    logic          w_data_stall;
    logic          w_md_stall;

    md_state_e     r_state;
    md_state_e     w_state_next;
    logic [7:0]    r_md_cnt;
    logic [7:0]    w_md_cnt_next;

    assign w_op       = instr_D[31:26];
    assign w_funct    = instr_D[5:0];
    assign w_rt_field = instr_D[20:16];
    // An all-zero word is a nop and must not decode as sll.
    assign w_rtype    = (w_op == 6'h00) && (instr_D != 32'h0);

    always_comb begin
        w_rs_use   = 1'b0;
        w_rt_use   = 1'b0;
        w_tuse_rs  = 2'd0;
        w_tuse_rt  = 2'd0;
        w_md_class = 1'b0;
        if (w_rtype) begin
            case (w_funct)
                6'h00, 6'h02, 6'h03: begin
                    w_rt_use = 1'b1; w_tuse_rt = 2'd1;
                end
                6'h04, 6'h06, 6'h07, 6'h21, 6'h23, 6'h25, 6'h2A: begin
                    w_rs_use = 1'b1; w_tuse_rs = 2'd1;
                    w_rt_use = 1'b1; w_tuse_rt = 2'd1;
                end
                6'h08, 6'h09: begin
                    w_rs_use = 1'b1; w_tuse_rs = 2'd0;
                end
                6'h10, 6'h12: w_md_class = 1'b1;
                6'h11, 6'h13: begin
                    w_rs_use = 1'b1; w_tuse_rs = 2'd1; w_md_class = 1'b1;
                end
                6'h18, 6'h19, 6'h1A, 6'h1B: begin
                    w_rs_use = 1'b1; w_tuse_rs = 2'd1;
                    w_rt_use = 1'b1; w_tuse_rt = 2'd1;
                    w_md_class = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (w_op)
                6'h04, 6'h05: begin
                    w_rs_use = 1'b1; w_tuse_rs = 2'd0;
                    w_rt_use = 1'b1; w_tuse_rt = 2'd0;
                end
                6'h06, 6'h07: begin
                    w_rs_use = 1'b1; w_tuse_rs = 2'd0;
                end
                6'h01: w_rs_use = (w_rt_field == 5'd0) || (w_rt_field == 5'd1);
                6'h0A, 6'h0D, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                    w_rs_use = 1'b1; w_tuse_rs = 2'd1;
                end
                6'h28, 6'h29, 6'h2B: begin
                    w_rs_use = 1'b1; w_tuse_rs = 2'd1;
                    w_rt_use = 1'b1; w_tuse_rt = 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign w_tuse_rs_tw = TW'(w_tuse_rs);
    assign w_tuse_rt_tw = TW'(w_tuse_rt);

    assign w_data_stall =
        (w_rs_use && rs_D != 5'd0 && rs_D == WAG_E && RegWrite_E && w_tuse_rs_tw < Tnew_E) ||
        (w_rs_use && rs_D != 5'd0 && rs_D == WAG_M && RegWrite_M && w_tuse_rs_tw < Tnew_M) ||
        (w_rt_use && rt_D != 5'd0 && rt_D == WAG_E && RegWrite_E && w_tuse_rt_tw < Tnew_E) ||
        (w_rt_use && rt_D != 5'd0 && rt_D == WAG_M && RegWrite_M && w_tuse_rt_tw < Tnew_M);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_md_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        case (r_state)
            StIdle: begin
                if (md_start_E) begin
                    w_state_next  = StBusy;
                    w_md_cnt_next = md_is_div_E ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
                end
            end
            StBusy: begin
                if (r_md_cnt == 8'd1) begin
                    w_state_next  = StIdle;
                    w_md_cnt_next = 8'd0;
                end else begin
                    w_md_cnt_next = r_md_cnt - 8'd1;
                end
            end
            default: begin
                w_state_next  = StIdle;
                w_md_cnt_next = 8'd0;
            end
        endcase
    end

    always_comb begin
        md_busy = (r_state == StBusy);
    end

    assign w_md_stall = w_md_class && (md_busy || md_start_E);
    assign stall      = w_data_stall || w_md_stall;
    assign flush_E    = stall;

`ifdef HAZARD_STALL_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (stats_clr) begin
            r_stall_cnt <= 16'd0;
        end else if (stall && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    logic w_unused_stats_clr;

    assign w_unused_stats_clr = stats_clr;
    assign stall_cnt          = 16'd0;
`endif

endmodule
